// File: rtl/edge_scan_pkg.sv
// Shared types and helpers for the edge_scan window scanner.
package edge_scan_pkg;

  localparam int DIR_W = 2;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_REQ   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4,
    ST_DRAIN = 3'd5
  } state_t;

  // Vertical scans walk along x first; horizontal scans walk along y first.
  function automatic logic dir_fast_is_x(input dir_t d);
    return (d == DIR_UP) || (d == DIR_DOWN);
  endfunction

  // UP and LEFT move the slow coordinate towards zero.
  function automatic logic dir_slow_dec(input dir_t d);
    return (d == DIR_UP) || (d == DIR_LEFT);
  endfunction

endpackage

// File: rtl/edge_scan_walker.sv
// Coordinate stepper: loads the start corner and advances fast/slow axes.
module scan_walker
  import edge_scan_pkg::*;
#(
  parameter int COORD_W  = 10,
  parameter int STRIDE_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_load,
  input  logic                i_step,
  input  logic [DIR_W-1:0]    i_dir,
  input  logic [COORD_W-1:0]  i_x0,
  input  logic [COORD_W-1:0]  i_y0,
  input  logic [COORD_W-1:0]  i_x1,
  input  logic [COORD_W-1:0]  i_y1,
  input  logic [STRIDE_W-1:0] i_stride,
  output logic [COORD_W-1:0]  o_cur_x,
  output logic [COORD_W-1:0]  o_cur_y,
  output logic                o_last
);

  localparam int EW = COORD_W + 1;

  dir_t               w_dir;
  logic [COORD_W-1:0] r_x, r_y;
  logic               w_fast_is_x, w_slow_dec;
  logic [COORD_W-1:0] w_fast_cur, w_fast_lo, w_fast_hi;
  logic [COORD_W-1:0] w_slow_cur, w_slow_lo, w_slow_hi;
  logic [EW-1:0]      w_stride, w_fast_sum, w_slow_next;
  logic               w_fast_ovf, w_slow_out;
  logic [COORD_W-1:0] w_next_fast, w_next_slow;
  logic [COORD_W-1:0] w_start_x, w_start_y;

  assign w_dir = dir_t'(i_dir);

  // Map x/y onto fast/slow axes and compute the next position and last flag.
  always_comb begin
    w_fast_is_x = dir_fast_is_x(w_dir);
    w_slow_dec  = dir_slow_dec(w_dir);
    if (w_fast_is_x) begin
      w_fast_cur = r_x;  w_fast_lo = i_x0; w_fast_hi = i_x1;
      w_slow_cur = r_y;  w_slow_lo = i_y0; w_slow_hi = i_y1;
    end else begin
      w_fast_cur = r_y;  w_fast_lo = i_y0; w_fast_hi = i_y1;
      w_slow_cur = r_x;  w_slow_lo = i_x0; w_slow_hi = i_x1;
    end
    // A zero stride would never advance, so it behaves as a stride of one.
    w_stride = (i_stride == {STRIDE_W{1'b0}}) ? {{(EW-1){1'b0}}, 1'b1}
                                              : {{(EW-STRIDE_W){1'b0}}, i_stride};
    w_fast_sum = {1'b0, w_fast_cur} + w_stride;
    w_fast_ovf = w_fast_sum > {1'b0, w_fast_hi};
    // One extra bit, treated as signed, so stepping below zero reads as -1.
    w_slow_next = w_slow_dec ? ({1'b0, w_slow_cur} - {{(EW-1){1'b0}}, 1'b1})
                             : ({1'b0, w_slow_cur} + {{(EW-1){1'b0}}, 1'b1});
    w_slow_out  = w_slow_dec ? ($signed(w_slow_next) < $signed({1'b0, w_slow_lo}))
                             : ($signed(w_slow_next) > $signed({1'b0, w_slow_hi}));
    w_next_fast = w_fast_ovf ? w_fast_lo : w_fast_sum[COORD_W-1:0];
    w_next_slow = w_fast_ovf ? w_slow_next[COORD_W-1:0] : w_slow_cur;
    case (w_dir)
      DIR_UP:    begin w_start_x = i_x0; w_start_y = i_y1; end
      DIR_DOWN:  begin w_start_x = i_x0; w_start_y = i_y0; end
      DIR_LEFT:  begin w_start_x = i_x1; w_start_y = i_y0; end
      DIR_RIGHT: begin w_start_x = i_x0; w_start_y = i_y0; end
      default:   begin w_start_x = i_x0; w_start_y = i_y0; end
    endcase
  end

  // Coordinate registers: load the start corner or take one scan step.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x <= {COORD_W{1'b0}};
      r_y <= {COORD_W{1'b0}};
    end else if (i_load) begin
      r_x <= w_start_x;
      r_y <= w_start_y;
    end else if (i_step) begin
      if (w_fast_is_x) begin
        r_x <= w_next_fast;
        r_y <= w_next_slow;
      end else begin
        r_x <= w_next_slow;
        r_y <= w_next_fast;
      end
    end
  end

  assign o_cur_x = r_x;
  assign o_cur_y = r_y;
  assign o_last  = w_fast_ovf && w_slow_out;

endmodule

// File: rtl/edge_scan.sv
// Window edge scanner: walks a window through the pixel cache until a pixel
// of the requested polarity is found or the window is exhausted.
module edge_scan
  import edge_scan_pkg::*;
#(
  parameter int COORD_W  = 10,
  parameter int STRIDE_W = 3,
  parameter int CNT_W    = 2 * COORD_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [COORD_W-1:0]  i_win_x0,
  input  logic [COORD_W-1:0]  i_win_y0,
  input  logic [COORD_W-1:0]  i_win_x1,
  input  logic [COORD_W-1:0]  i_win_y1,
  input  logic [DIR_W-1:0]    i_dir,
  input  logic                i_match_pol,
  input  logic [STRIDE_W-1:0] i_stride,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_found,
  output logic                o_err,
  output logic [COORD_W-1:0]  o_hit_x,
  output logic [COORD_W-1:0]  o_hit_y,
  output logic [CNT_W-1:0]    o_checked,
  output logic                o_req_valid,
  input  logic                i_req_ready,
  output logic [COORD_W-1:0]  o_req_x,
  output logic [COORD_W-1:0]  o_req_y,
  input  logic                i_rsp_valid,
  input  logic                i_rsp_pixel
);

  state_t              r_state;
  logic [COORD_W-1:0]  r_x0, r_y0, r_x1, r_y1;
  logic [DIR_W-1:0]    r_dir;
  logic                r_pol;
  logic [STRIDE_W-1:0] r_stride;
  logic                r_busy, r_done, r_found, r_err, r_req_valid;
  logic [COORD_W-1:0]  r_hit_x, r_hit_y;
  logic [CNT_W-1:0]    r_checked;

  logic [COORD_W-1:0]  w_cur_x, w_cur_y;
  logic                w_last, w_win_bad, w_match, w_load, w_step;
  logic [CNT_W-1:0]    w_cnt_inc;

  assign w_win_bad = (r_x0 > r_x1) || (r_y0 > r_y1);
  assign w_match   = (i_rsp_pixel == r_pol);
  assign w_load    = (r_state == ST_LOAD) && !i_abort && !w_win_bad;
  assign w_step    = (r_state == ST_WAIT) && !i_abort && i_rsp_valid && !w_match && !w_last;
  assign w_cnt_inc = (&r_checked) ? r_checked : (r_checked + {{(CNT_W-1){1'b0}}, 1'b1});

  scan_walker #(
    .COORD_W  (COORD_W),
    .STRIDE_W (STRIDE_W)
  ) u_walker (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_dir    (r_dir),
    .i_x0     (r_x0),
    .i_y0     (r_y0),
    .i_x1     (r_x1),
    .i_y1     (r_y1),
    .i_stride (r_stride),
    .o_cur_x  (w_cur_x),
    .o_cur_y  (w_cur_y),
    .o_last   (w_last)
  );

  // Scan control FSM with registered status and request outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_x0        <= {COORD_W{1'b0}};
      r_y0        <= {COORD_W{1'b0}};
      r_x1        <= {COORD_W{1'b0}};
      r_y1        <= {COORD_W{1'b0}};
      r_dir       <= {DIR_W{1'b0}};
      r_pol       <= 1'b0;
      r_stride    <= {STRIDE_W{1'b0}};
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_found     <= 1'b0;
      r_err       <= 1'b0;
      r_req_valid <= 1'b0;
      r_hit_x     <= {COORD_W{1'b0}};
      r_hit_y     <= {COORD_W{1'b0}};
      r_checked   <= {CNT_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_state   <= ST_LOAD;
            r_x0      <= i_win_x0;
            r_y0      <= i_win_y0;
            r_x1      <= i_win_x1;
            r_y1      <= i_win_y1;
            r_dir     <= i_dir;
            r_pol     <= i_match_pol;
            r_stride  <= i_stride;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_found   <= 1'b0;
            r_err     <= 1'b0;
            r_hit_x   <= {COORD_W{1'b0}};
            r_hit_y   <= {COORD_W{1'b0}};
            r_checked <= {CNT_W{1'b0}};
          end
        end
        ST_LOAD: begin
          if (i_abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_win_bad) begin
            r_state <= ST_DONE;
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_state     <= ST_REQ;
            r_req_valid <= 1'b1;
          end
        end
        ST_REQ: begin
          if (i_abort) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_req_valid <= 1'b0;
          end else if (i_req_ready) begin
            r_state     <= ST_WAIT;
            r_req_valid <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (i_abort) begin
            // A response landing with the abort is the outstanding one.
            if (i_rsp_valid) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_DRAIN;
            end
          end else if (i_rsp_valid) begin
            r_checked <= w_cnt_inc;
            if (w_match) begin
              r_state <= ST_DONE;
              r_found <= 1'b1;
              r_hit_x <= w_cur_x;
              r_hit_y <= w_cur_y;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else if (w_last) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state     <= ST_REQ;
              r_req_valid <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (i_rsp_valid) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_req_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_found     = r_found;
  assign o_err       = r_err;
  assign o_hit_x     = r_hit_x;
  assign o_hit_y     = r_hit_y;
  assign o_checked   = r_checked;
  assign o_req_valid = r_req_valid;
  assign o_req_x     = w_cur_x;
  assign o_req_y     = w_cur_y;

endmodule
